// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial memory controller.
package mem_ctrl_pkg;

  localparam int          MC_XLEN        = 32;
  localparam int          ROB_SIZE_WIDTH = 4;
  localparam logic [31:0] MC_IO_BASE     = 32'h0003_0000;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_READ  = 2'd1,
    MC_WRITE = 2'd2
  } mc_state_e;

  typedef enum logic {
    SRC_IF  = 1'b0,
    SRC_LSB = 1'b1
  } mc_src_e;

  // Number of bus bytes for a width code; the unused code 3 behaves as a word.
  function automatic logic [2:0] width_to_len(input logic [1:0] width);
    case (width)
      MEM_BYTE: return 3'd1;
      MEM_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_load_extend.sv
// Zero/sign extension of an assembled little-endian load word.
module mem_ctrl_load_extend
  import mem_ctrl_pkg::*;
#(
  parameter int XLEN = MC_XLEN
) (
  input  logic [XLEN-1:0] raw,
  input  logic [1:0]      width,
  input  logic            is_signed,
  output logic [XLEN-1:0] ext
);

  // Extend the low byte/half according to width; words pass through.
  always_comb begin
    ext = raw;
    case (width)
      MEM_BYTE: ext = {{(XLEN-8){is_signed & raw[7]}}, raw[7:0]};
      MEM_HALF: ext = {{(XLEN-16){is_signed & raw[15]}}, raw[15:0]};
      default:  ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates ifetch and LSB onto one 8-bit bus.
//
// state    | meaning
// MC_IDLE  | bus free, grant a pending request (unless flush)
// MC_READ  | issue read addresses, collect bytes one cycle behind
// MC_WRITE | drive one store byte per cycle, stalled by IO back-pressure
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int              XLEN         = MC_XLEN,
  parameter int              ROB_ID_WIDTH = ROB_SIZE_WIDTH,
  parameter logic [XLEN-1:0] IO_BASE      = XLEN'(MC_IO_BASE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    flush,
  input  logic                    io_buffer_full,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [XLEN-1:0]         mem_a,
  output logic                    mem_wr,
  input  logic                    if_req,
  input  logic [XLEN-1:0]         if_addr,
  output logic                    if_done,
  output logic [XLEN-1:0]         if_data,
  input  logic                    lsb_req,
  input  logic                    lsb_wr,
  input  logic [1:0]              lsb_width,
  input  logic                    lsb_signed,
  input  logic [XLEN-1:0]         lsb_addr,
  input  logic [XLEN-1:0]         lsb_wdata,
  input  logic [ROB_ID_WIDTH-1:0] lsb_id,
  output logic                    mem_busy,
  output logic                    mem_data_ready,
  output logic [XLEN-1:0]         mem_data,
  output logic [ROB_ID_WIDTH-1:0] mem_id,
  output logic                    lsb_store_done
);

  localparam int NBYTES = XLEN / 8;

  mc_state_e               state_q, state_d;
  mc_src_e                 src_q, src_d;
  mc_src_e                 last_grant_q, last_grant_d;
  logic [XLEN-1:0]         addr_q, addr_d;
  logic [2:0]              len_q, len_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [XLEN-1:0]         wdata_q, wdata_d;
  logic [ROB_ID_WIDTH-1:0] id_q, id_d;
  logic                    signed_q, signed_d;
  logic [1:0]              width_q, width_d;
  logic [XLEN-1:0]         rdata_q, rdata_d;
  logic                    if_done_q, if_done_d;
  logic [XLEN-1:0]         if_data_q, if_data_d;
  logic                    mem_data_ready_q, mem_data_ready_d;
  logic [XLEN-1:0]         mem_data_q, mem_data_d;
  logic [ROB_ID_WIDTH-1:0] mem_id_q, mem_id_d;
  logic                    store_done_q, store_done_d;

  logic [XLEN-1:0] cur_addr;
  logic [XLEN-1:0] rd_merged;
  logic [XLEN-1:0] ext_data;
  logic [7:0]      wr_byte;
  logic            io_block;
  logic            pick_lsb;
  logic            pick_if;

  assign cur_addr = addr_q + XLEN'(cnt_q);
  assign wr_byte  = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
  assign io_block = (cur_addr >= IO_BASE) && io_buffer_full;
  // LSB wins a tie unless it was the last one served.
  assign pick_lsb = lsb_req & (~if_req | (last_grant_q == SRC_IF));
  assign pick_if  = if_req & ~pick_lsb;

  // Byte k of a read lands on mem_din while cnt_q == k+1; merge it into the word.
  always_comb begin
    rd_merged = rdata_q;
    for (int i = 0; i < NBYTES; i++) begin
      if (cnt_q == 3'(i + 1)) rd_merged[8*i +: 8] = mem_din;
    end
  end

  mem_ctrl_load_extend #(.XLEN(XLEN)) u_load_extend (
    .raw       (rd_merged),
    .width     (width_q),
    .is_signed (signed_q),
    .ext       (ext_data)
  );

  // Next-state, grant latching, byte sequencing and completion pulses.
  always_comb begin
    state_d          = state_q;
    src_d            = src_q;
    last_grant_d     = last_grant_q;
    addr_d           = addr_q;
    len_d            = len_q;
    cnt_d            = cnt_q;
    wdata_d          = wdata_q;
    id_d             = id_q;
    signed_d         = signed_q;
    width_d          = width_q;
    rdata_d          = rdata_q;
    if_done_d        = 1'b0;
    if_data_d        = if_data_q;
    mem_data_ready_d = 1'b0;
    mem_data_d       = mem_data_q;
    mem_id_d         = mem_id_q;
    store_done_d     = 1'b0;

    case (state_q)
      MC_IDLE: begin
        if (!flush && pick_lsb) begin
          src_d        = SRC_LSB;
          last_grant_d = SRC_LSB;
          addr_d       = lsb_addr;
          len_d        = width_to_len(lsb_width);
          width_d      = lsb_width;
          signed_d     = lsb_signed;
          id_d         = lsb_id;
          wdata_d      = lsb_wdata;
          cnt_d        = 3'd0;
          rdata_d      = '0;
          state_d      = lsb_wr ? MC_WRITE : MC_READ;
        end else if (!flush && pick_if) begin
          src_d        = SRC_IF;
          last_grant_d = SRC_IF;
          addr_d       = if_addr;
          len_d        = 3'd4;
          width_d      = MEM_WORD;
          signed_d     = 1'b0;
          cnt_d        = 3'd0;
          rdata_d      = '0;
          state_d      = MC_READ;
        end
      end

      MC_READ: begin
        if (flush) begin
          state_d = MC_IDLE;
          cnt_d   = 3'd0;
        end else begin
          if (cnt_q != 3'd0) rdata_d = rd_merged;
          if (cnt_q == len_q) begin
            state_d = MC_IDLE;
            cnt_d   = 3'd0;
            if (src_q == SRC_IF) begin
              if_done_d = 1'b1;
              if_data_d = rd_merged;
            end else begin
              mem_data_ready_d = 1'b1;
              mem_data_d       = ext_data;
              mem_id_d         = id_q;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      MC_WRITE: begin
        // Stores are already committed, so flush does not stop them.
        if (!io_block) begin
          if (cnt_q == len_q - 3'd1) begin
            state_d      = MC_IDLE;
            cnt_d        = 3'd0;
            store_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      default: state_d = MC_IDLE;
    endcase
  end

  // State register; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= MC_IDLE;
      src_q            <= SRC_IF;
      last_grant_q     <= SRC_IF;
      addr_q           <= '0;
      len_q            <= '0;
      cnt_q            <= '0;
      wdata_q          <= '0;
      id_q             <= '0;
      signed_q         <= 1'b0;
      width_q          <= '0;
      rdata_q          <= '0;
      if_done_q        <= 1'b0;
      if_data_q        <= '0;
      mem_data_ready_q <= 1'b0;
      mem_data_q       <= '0;
      mem_id_q         <= '0;
      store_done_q     <= 1'b0;
    end else if (rdy) begin
      state_q          <= state_d;
      src_q            <= src_d;
      last_grant_q     <= last_grant_d;
      addr_q           <= addr_d;
      len_q            <= len_d;
      cnt_q            <= cnt_d;
      wdata_q          <= wdata_d;
      id_q             <= id_d;
      signed_q         <= signed_d;
      width_q          <= width_d;
      rdata_q          <= rdata_d;
      if_done_q        <= if_done_d;
      if_data_q        <= if_data_d;
      mem_data_ready_q <= mem_data_ready_d;
      mem_data_q       <= mem_data_d;
      mem_id_q         <= mem_id_d;
      store_done_q     <= store_done_d;
    end
  end

  // Bus drive is derived from the current state; idle bus shows zeros.
  always_comb begin
    mem_a    = (state_q == MC_IDLE) ? '0 : cur_addr;
    mem_dout = (state_q == MC_WRITE) ? wr_byte : 8'h00;
    mem_wr   = rdy && (state_q == MC_WRITE) && !io_block;
  end

  assign mem_busy       = (state_q != MC_IDLE);
  assign if_done        = if_done_q;
  assign if_data        = if_data_q;
  assign mem_data_ready = mem_data_ready_q;
  assign mem_data       = mem_data_q;
  assign mem_id         = mem_id_q;
  assign lsb_store_done = store_done_q;

endmodule
